sram_like_to_axi_bridge: RTL

//  Downstream of the instruction and data sram_like front-ends; converts both sram_like ports to one AXI3 master.

---
 rtl/sram_like_to_axi_bridge_pkg.sv | 31 +++
 rtl/sram_like_to_axi_bridge_read.sv | 104 ++++++++++
 rtl/sram_like_to_axi_bridge.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_like_to_axi_bridge_pkg.sv
// Shared state encodings, ownership tags and AXI3 constants for the sram_like to AXI3 bridge.
package sram_like_to_axi_bridge_pkg;

   typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_AR = 2'd1, RD_R = 2'd2} rd_state_e;
   typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_AW_W = 2'd1, WR_B = 2'd2} wr_state_e;
   typedef enum logic {OWNER_INST = 1'b0, OWNER_DATA = 1'b1} owner_e;

   localparam logic [3:0] AXI_LEN_SINGLE   = 4'd0;
   localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
   localparam logic [1:0] AXI_LOCK_NORMAL  = 2'b00;
   localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;
   localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;

   function automatic logic [2:0] axi_size(input logic [1:0] size);
      return {1'b0, size};
   endfunction

   function automatic logic [3:0] axi_cache(input logic cache);
      return cache ? 4'b1111 : 4'b0000;
   endfunction

   // Size 3 is not a legal sram_like size; it is treated as a full word.
   function automatic logic [3:0] wstrb_for(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         2'd0:    return 4'b0001 << addr_lo;
         2'd1:    return addr_lo[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/sram_like_to_axi_bridge_read.sv
// Shared AXI read channel: arbitrates inst/data reads (data wins ties) and runs one AR/R transfer at a time.
module axi_read_channel
   import sram_like_to_axi_bridge_pkg::*;
#(
   parameter logic [3:0] INST_ARID = 4'd0,
   parameter logic [3:0] DATA_ID   = 4'd1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        inst_req_i,
   input  logic [1:0]  inst_size_i,
   input  logic [31:0] inst_addr_i,
   input  logic        inst_cache_i,
   input  logic        data_req_i,
   input  logic [1:0]  data_size_i,
   input  logic [31:0] data_addr_i,
   input  logic        data_cache_i,
   output logic        inst_addr_ok_o,
   output logic        data_addr_ok_o,
   output logic        inst_data_ok_o,
   output logic        data_data_ok_o,
   output logic [31:0] inst_rdata_o,
   output logic [31:0] data_rdata_o,
   output logic [3:0]  arid_o,
   output logic [31:0] araddr_o,
   output logic [2:0]  arsize_o,
   output logic [3:0]  arcache_o,
   output logic        arvalid_o,
   input  logic        arready_i,
   input  logic [31:0] rdata_i,
   input  logic        rvalid_i,
   output logic        rready_o
);

   rd_state_e   state_q, state_d;
   owner_e      owner_q, owner_d;
   logic [31:0] addr_q;
   logic [1:0]  size_q;
   logic        cache_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= RD_IDLE;
         owner_q <= OWNER_INST;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   // Request attributes only need capturing on the accept cycle.
   always_ff @(posedge clock) begin
      if (inst_addr_ok_o || data_addr_ok_o) begin
         addr_q  <= data_addr_ok_o ? data_addr_i  : inst_addr_i;
         size_q  <= data_addr_ok_o ? data_size_i  : inst_size_i;
         cache_q <= data_addr_ok_o ? data_cache_i : inst_cache_i;
      end
   end

   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      inst_addr_ok_o = 1'b0;
      data_addr_ok_o = 1'b0;
      inst_data_ok_o = 1'b0;
      data_data_ok_o = 1'b0;
      arvalid_o      = 1'b0;
      rready_o       = 1'b0;
      case (state_q)
         RD_IDLE: begin
            if (data_req_i) begin
               data_addr_ok_o = 1'b1;
               owner_d        = OWNER_DATA;
               state_d        = RD_AR;
            end else if (inst_req_i) begin
               inst_addr_ok_o = 1'b1;
               owner_d        = OWNER_INST;
               state_d        = RD_AR;
            end
         end
         RD_AR: begin
            arvalid_o = 1'b1;
            if (arready_i) state_d = RD_R;
         end
         RD_R: begin
            rready_o = 1'b1;
            if (rvalid_i) begin
               inst_data_ok_o = (owner_q == OWNER_INST);
               data_data_ok_o = (owner_q == OWNER_DATA);
               state_d        = RD_IDLE;
            end
         end
         default: state_d = RD_IDLE;
      endcase
   end

   assign inst_rdata_o = inst_data_ok_o ? rdata_i : 32'd0;
   assign data_rdata_o = data_data_ok_o ? rdata_i : 32'd0;
   assign arid_o       = (owner_q == OWNER_DATA) ? DATA_ID : INST_ARID;
   assign araddr_o     = addr_q;
   assign arsize_o     = axi_size(size_q);
   assign arcache_o    = axi_cache(cache_q);

endmodule

// File: rtl/sram_like_to_axi_bridge.sv
// Converts the inst and data sram_like ports into one single-beat AXI3 master; data writes use their own channel.
// Optional BRIDGE_ERR_LOG_EN adds a sticky error flag/address capture of the first non-OKAY response.
module sram_like_to_axi_bridge
   import sram_like_to_axi_bridge_pkg::*;
#(
   parameter logic [3:0] INST_ARID = 4'd0,
   parameter logic [3:0] DATA_ID   = 4'd1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   input  logic        inst_cache,
   output logic [31:0] inst_rdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic        data_cache,
   output logic [31:0] data_rdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [3:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [3:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,
   output logic [3:0]  wid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic [3:0]  bid,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
`ifdef BRIDGE_ERR_LOG_EN
   ,
   output logic        err_valid,
   output logic [31:0] err_addr
`endif
);

   wr_state_e   wr_state_q, wr_state_d;
   logic        aw_pend_q, aw_pend_d;
   logic        w_pend_q, w_pend_d;
   logic        data_busy_q, data_busy_d;
   logic [31:0] awaddr_q, wdata_q;
   logic [1:0]  wsize_q;
   logic        wcache_q;

   logic        data_rd_req, data_wr_acc;
   logic        rd_data_addr_ok, rd_data_ok, wr_data_ok;

   // Data port keeps at most one transaction outstanding across both channels.
   assign data_rd_req = data_req & ~data_wr & ~data_busy_q;
   assign data_wr_acc = (wr_state_q == WR_IDLE) & data_req & data_wr & ~data_busy_q;

   axi_read_channel #(
      .INST_ARID (INST_ARID),
      .DATA_ID   (DATA_ID)
   ) u_read (
      .clock          (clock),
      .reset          (reset),
      .inst_req_i     (inst_req),
      .inst_size_i    (inst_size),
      .inst_addr_i    (inst_addr),
      .inst_cache_i   (inst_cache),
      .data_req_i     (data_rd_req),
      .data_size_i    (data_size),
      .data_addr_i    (data_addr),
      .data_cache_i   (data_cache),
      .inst_addr_ok_o (inst_addr_ok),
      .data_addr_ok_o (rd_data_addr_ok),
      .inst_data_ok_o (inst_data_ok),
      .data_data_ok_o (rd_data_ok),
      .inst_rdata_o   (inst_rdata),
      .data_rdata_o   (data_rdata),
      .arid_o         (arid),
      .araddr_o       (araddr),
      .arsize_o       (arsize),
      .arcache_o      (arcache),
      .arvalid_o      (arvalid),
      .arready_i      (arready),
      .rdata_i        (rdata),
      .rvalid_i       (rvalid),
      .rready_o       (rready)
   );

   assign data_addr_ok = rd_data_addr_ok | data_wr_acc;
   assign data_data_ok = rd_data_ok | wr_data_ok;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_state_q  <= WR_IDLE;
         aw_pend_q   <= 1'b0;
         w_pend_q    <= 1'b0;
         data_busy_q <= 1'b0;
      end else begin
         wr_state_q  <= wr_state_d;
         aw_pend_q   <= aw_pend_d;
         w_pend_q    <= w_pend_d;
         data_busy_q <= data_busy_d;
      end
   end

   always_ff @(posedge clock) begin
      if (data_wr_acc) begin
         awaddr_q <= data_addr;
         wdata_q  <= data_wdata;
         wsize_q  <= data_size;
         wcache_q <= data_cache;
      end
   end

   // AW and W each retire on their own ready; the B phase starts once both are gone.
   always_comb begin
      wr_state_d  = wr_state_q;
      aw_pend_d   = aw_pend_q;
      w_pend_d    = w_pend_q;
      wr_data_ok  = 1'b0;
      bready      = 1'b0;
      case (wr_state_q)
         WR_IDLE: begin
            if (data_wr_acc) begin
               aw_pend_d  = 1'b1;
               w_pend_d   = 1'b1;
               wr_state_d = WR_AW_W;
            end
         end
         WR_AW_W: begin
            aw_pend_d = aw_pend_q & ~awready;
            w_pend_d  = w_pend_q & ~wready;
            if (!aw_pend_d && !w_pend_d) wr_state_d = WR_B;
         end
         WR_B: begin
            bready = 1'b1;
            if (bvalid) begin
               wr_data_ok = 1'b1;
               wr_state_d = WR_IDLE;
            end
         end
         default: wr_state_d = WR_IDLE;
      endcase
      data_busy_d = data_data_ok ? 1'b0 : (data_addr_ok ? 1'b1 : data_busy_q);
   end

   assign awvalid = (wr_state_q == WR_AW_W) & aw_pend_q;
   assign wvalid  = (wr_state_q == WR_AW_W) & w_pend_q;
   assign awid    = DATA_ID;
   assign awaddr  = awaddr_q;
   assign awsize  = axi_size(wsize_q);
   assign awcache = axi_cache(wcache_q);
   assign wid     = DATA_ID;
   assign wdata   = wdata_q;
   assign wstrb   = wstrb_for(wsize_q, awaddr_q[1:0]);
   assign wlast   = 1'b1;

   assign arlen   = AXI_LEN_SINGLE;
   assign arburst = AXI_BURST_INCR;
   assign arlock  = AXI_LOCK_NORMAL;
   assign arprot  = AXI_PROT_DEFAULT;
   assign awlen   = AXI_LEN_SINGLE;
   assign awburst = AXI_BURST_INCR;
   assign awlock  = AXI_LOCK_NORMAL;
   assign awprot  = AXI_PROT_DEFAULT;

`ifdef BRIDGE_ERR_LOG_EN
   logic        err_valid_q;
   logic [31:0] err_addr_q;
   logic        r_err, b_err;

   assign r_err = rready & rvalid & (rresp != AXI_RESP_OKAY);
   assign b_err = bready & bvalid & (bresp != AXI_RESP_OKAY);

   // Only the first failing response is recorded; read wins if both fail together.
   always_ff @(posedge clock) begin
      if (reset) begin
         err_valid_q <= 1'b0;
         err_addr_q  <= 32'd0;
      end else if (!err_valid_q && (r_err || b_err)) begin
         err_valid_q <= 1'b1;
         err_addr_q  <= r_err ? araddr : awaddr_q;
      end
   end

   assign err_valid = err_valid_q;
   assign err_addr  = err_addr_q;
`endif

   logic unused_inputs;
   assign unused_inputs = &{1'b0, inst_wr, inst_wdata, rid, rresp, rlast, bid, bresp};

endmodule
